// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control units: FSM states, opcodes and
// the alusrcb / pcsrc / aluop control field values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with retired-instruction
// counter. Define MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready_i.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pcen_o,
  output logic             iord_o,
  output logic             memwrite_o,
  output logic             irwrite_o,
  output logic             regdst_o,
  output logic             memtoreg_o,
  output logic             regwrite_o,
  output logic             alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [1:0]       pcsrc_o,
  output logic [1:0]       aluop_o,
  output logic             illegal_op_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             pcwrite, branch, terminal, mem_ok;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    terminal     = 1'b0;
    iord_o       = 1'b0;
    memwrite_o   = 1'b0;
    irwrite_o    = 1'b0;
    regdst_o     = 1'b0;
    memtoreg_o   = 1'b0;
    regwrite_o   = 1'b0;
    alusrca_o    = 1'b0;
    alusrcb_o    = SRCB_B;
    pcsrc_o      = PCSRC_ALU;
    aluop_o      = ALUOP_ADD;
    illegal_op_o = 1'b0;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        irwrite_o = mem_ok;
        pcwrite   = mem_ok;
        alusrcb_o = SRCB_FOUR;
        aluop_o   = ALUOP_ADD;
        if (mem_ok) state_d = StDecode;
      end
      StDecode: begin
        alusrcb_o = SRCB_IMM_SH;
        case (op_i)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default: begin
            illegal_op_o = 1'b1;
            state_d      = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        if (op_i == OP_LW)      state_d = StMemRd;
        else if (op_i == OP_SW) state_d = StMemWr;
        else                    state_d = StFetch;
      end
      StMemRd: begin
        iord_o = 1'b1;
        if (mem_ok) state_d = StMemWb;
      end
      StMemWb: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
        terminal   = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord_o     = 1'b1;
        memwrite_o = mem_ok;
        terminal   = 1'b1;
        if (mem_ok) state_d = StFetch;
      end
      StExecute: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_B;
        aluop_o   = ALUOP_FUNCT;
        state_d   = StAluWb;
      end
      StAluWb: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
        terminal   = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_B;
        aluop_o   = ALUOP_SUB;
        branch    = 1'b1;
        pcsrc_o   = PCSRC_ALUOUT;
        terminal  = 1'b1;
        state_d   = StFetch;
      end
      StAddiEx: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALUOP_ADD;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        regwrite_o = 1'b1;
        terminal   = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pcwrite  = 1'b1;
        pcsrc_o  = PCSRC_JUMP;
        terminal = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign pcen_o = pcwrite | (branch & zero_i);

  // A stalled MEMWR is terminal but not yet leaving, so gate on the transition.
  always_comb begin
    retired_d = retired_q;
    if (terminal && state_d == StFetch) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StReset;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-cycle expected control vectors are queued per
// instruction and popped against the DUT outputs at each falling edge.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CntW = 4;

  localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMW = 4, SMWR = 5, SEX = 6, SAWB = 7,
                 SBR = 8, SAEX = 9, SAIWB = 10, SJ = 11;

  typedef struct {
    logic [14:0] ctl;
    int          st;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [5:0]      op_i;
  logic            zero_i;
  logic            mem_ready_i;
  logic            pcen_o, iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o;
  logic            regwrite_o, alusrca_o, illegal_op_o;
  logic [1:0]      alusrcb_o, pcsrc_o, aluop_o;
  logic [CntW-1:0] retired_o;
  logic [14:0]     act;

  exp_t            sb[$];
  int              n_checks = 0;
  int              n_pass = 0;
  logic [CntW-1:0] exp_ret = '0;

  mips_multicycle_ctrl #(.CNT_W(CntW)) u_dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .op_i         (op_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pcen_o       (pcen_o),
    .iord_o       (iord_o),
    .memwrite_o   (memwrite_o),
    .irwrite_o    (irwrite_o),
    .regdst_o     (regdst_o),
    .memtoreg_o   (memtoreg_o),
    .regwrite_o   (regwrite_o),
    .alusrca_o    (alusrca_o),
    .alusrcb_o    (alusrcb_o),
    .pcsrc_o      (pcsrc_o),
    .aluop_o      (aluop_o),
    .illegal_op_o (illegal_op_o),
    .retired_o    (retired_o)
  );

  always #5 clk_i = ~clk_i;

  assign act = {pcen_o, iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o,
                alusrca_o, alusrcb_o, pcsrc_o, aluop_o, illegal_op_o};

  // Field order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca
  // alusrcb pcsrc aluop illegal_op.
  function automatic logic [14:0] exp_ctl(int st, logic z, logic rdy, logic ill);
    logic [14:0] v;
    case (st)
      SF:    v = {rdy, 1'b0, 1'b0, rdy, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
      SD:    v = {8'b0, 2'b11, 2'b00, 2'b00, ill};
      SMA:   v = {7'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      SMR:   v = {1'b0, 1'b1, 6'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      SMW:   v = {5'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      SMWR:  v = {1'b0, 1'b1, rdy, 5'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      SEX:   v = {7'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0};
      SAWB:  v = {4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      SBR:   v = {z, 6'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
      SAEX:  v = {7'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      SAIWB: v = {6'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      SJ:    v = {1'b1, 7'b0, 2'b00, 2'b10, 2'b00, 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
           op == 6'b001000 || op == 6'b000010;
  endfunction

  task automatic push(int st, logic z, logic ill);
    exp_t e;
    e.ctl = exp_ctl(st, z, 1'b1, ill);
    e.st  = st;
    sb.push_back(e);
  endtask

  // Entered and left at a falling edge with the DUT in FETCH.
  task automatic test_instr(input string nm, input logic [5:0] op, input logic z);
    exp_t e;
    int   cyc = 0;
    op_i   = op;
    zero_i = z;
    push(SF, z, 1'b0);
    push(SD, z, !is_legal(op));
    case (op)
      6'b100011: begin push(SMA, z, 0); push(SMR, z, 0); push(SMW, z, 0); end
      6'b101011: begin push(SMA, z, 0); push(SMWR, z, 0); end
      6'b000000: begin push(SEX, z, 0); push(SAWB, z, 0); end
      6'b000100: push(SBR, z, 0);
      6'b001000: begin push(SAEX, z, 0); push(SAIWB, z, 0); end
      6'b000010: push(SJ, z, 0);
      default: ;
    endcase
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (act !== e.ctl)
        $display("FAIL %s cycle %0d state %0d: ctl got %b want %b", nm, cyc, e.st, act, e.ctl);
      else n_pass++;
      cyc++;
      @(negedge clk_i);
    end
    if (is_legal(op)) exp_ret = exp_ret + 1'b1;
    n_checks++;
    if (retired_o !== exp_ret)
      $display("FAIL %s retired: got %0d want %0d", nm, retired_o, exp_ret);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (act !== 15'b0 || retired_o !== '0)
      $display("FAIL reset_hold: ctl %b ret %0d want 0/0", act, retired_o);
    else n_pass++;
    reset_ni = 1'b1;
    #1;
    n_checks++;
    if (act !== 15'b0) $display("FAIL reset_state: ctl got %b want 0", act);
    else n_pass++;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_memrd();
    op_i = 6'b100011;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (act !== exp_ctl(SMR, 1'b0, 1'b1, 1'b0))
      $display("FAIL mid_memrd: ctl got %b want %b", act, exp_ctl(SMR, 1'b0, 1'b1, 1'b0));
    else n_pass++;
    reset_ni = 1'b0;
    #1;
    n_checks++;
    if (act !== 15'b0 || retired_o !== '0)
      $display("FAIL reset_async: ctl %b ret %0d want 0/0", act, retired_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (act !== 15'b0) $display("FAIL reset_no_write: ctl got %b want 0", act);
    else n_pass++;
    reset_ni = 1'b1;
    #1;
    n_checks++;
    if (act !== 15'b0) $display("FAIL reset_release: ctl got %b want 0", act);
    else n_pass++;
    @(negedge clk_i);
    exp_ret = '0;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (act !== exp_ctl(SF, 1'b0, 1'b0, 1'b0))
        $display("FAIL fetch_stall %0d: ctl got %b want %b", i, act,
                 exp_ctl(SF, 1'b0, 1'b0, 1'b0));
      else n_pass++;
      @(negedge clk_i);
    end
    mem_ready_i = 1'b1;
    test_instr("after_stall", 6'b000010, 1'b0);
  endtask
`endif

  initial begin
    logic [5:0] ops[7];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b010101};
    op_i   = 6'b0;
    zero_i = 1'b0;
`ifdef MEM_WAIT_EN
    mem_ready_i = 1'b1;
`else
    mem_ready_i = 1'b0;
`endif
    test_reset();
    test_instr("lw", 6'b100011, 1'b0);
    test_instr("beq_taken", 6'b000100, 1'b1);
    test_instr("beq_not_taken", 6'b000100, 1'b0);
    test_reset_mid_memrd();
    test_instr("mix_r", 6'b000000, 1'b0);
    test_instr("mix_sw", 6'b101011, 1'b1);
    test_instr("mix_addi", 6'b001000, 1'b0);
    test_instr("mix_j", 6'b000010, 1'b1);
    test_instr("illegal", 6'b111111, 1'b0);
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    for (int i = 0; i < 24; i++)
      test_instr("back_to_back", ops[$urandom_range(6)], 1'($urandom_range(1)));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-FSM control unit for the multicycle MIPS datapath variant.
- Supports the same ISA subset as the pipelined core: R-type, LW, SW, BEQ, ADDI, J.
- Sequences one instruction over 3–5 cycles using the shared IR, register file, ALU and unified memory.
- Drives the datapath mux/enable controls; aluop feeds the existing ALU decoder unchanged.
- Also counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  6  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- pcen  out  1  PC write enable = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  write data: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B: 00 = B reg, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- aluop  out  2  00 = add, 01 = sub, 10 = use funct
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Async reset (reset_n low):
  - state = S_RESET, retired = 0.
  - All outputs 0 while in S_RESET.
  - Reset mid-instruction abandons it; no partial writes after reset asserts.
- S_RESET -> FETCH unconditionally on the first clock after release.
- Controls asserted per state; anything unlisted is 0:
  - FETCH: irwrite, alusrcb=01, pcwrite, aluop=00. -> DECODE
  - DECODE: alusrcb=11 (branch target precompute). Next state by op:
    - LW/SW (100011/101011) -> MEMADR
    - R-type (000000) -> EXECUTE
    - BEQ (000100) -> BRANCH
    - ADDI (001000) -> ADDIEX
    - J (000010) -> JUMP
    - any other op -> FETCH, with illegal_op pulsed during DECODE; retired not incremented
  - MEMADR: alusrca, alusrcb=10. -> MEMRD (LW) or MEMWR (SW); op is sampled from the stable IR.
  - MEMRD: iord. -> MEMWB
  - MEMWB: regwrite, memtoreg, regdst=0. -> FETCH
  - MEMWR: iord, memwrite. -> FETCH
  - EXECUTE: alusrca, alusrcb=00, aluop=10. -> ALUWB
  - ALUWB: regwrite, regdst=1. -> FETCH
  - BRANCH: alusrca, alusrcb=00, aluop=01, branch, pcsrc=01. -> FETCH
  - ADDIEX: alusrca, alusrcb=10, aluop=00. -> ADDIWB
  - ADDIWB: regwrite, regdst=0. -> FETCH
  - JUMP: pcwrite, pcsrc=10. -> FETCH
- branch and pcwrite are internal; only pcen is exported.
- Latency (cycles, FETCH to next FETCH): BEQ 3, J 3, R-type 4, SW 4, ADDI 4, LW 5.
- retired increments by 1 on each transition into FETCH from a terminal state: MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP. It wraps silently.
- No X on any output in any state; undefined encodings recover to FETCH.

Optional Feature:
- MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready = 1.
  - irwrite and pcwrite in FETCH, and memwrite in MEMWR, are qualified by mem_ready so each fires exactly once.
- MEM_WAIT_EN undefined: mem_ready is ignored; every memory access takes one cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - alusrcb, pcsrc and aluop encodings
- The pipelined decoder reuses the same opcode and aluop constants.
- Single module; no sub-module is needed. The counter is inline.

Test Plan:
- Reset: reset_n low mid-MEMRD, then release -> all outputs 0 for one cycle (S_RESET); FETCH next with irwrite=1, alusrcb=01; retired=0.
- LW: op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in the 5th; retired +1.
- BEQ: op=000100 with zero=1 -> pcen=1 in BRANCH with pcsrc=01. With zero=0 -> pcen=0. Each takes 3 cycles.
- Mixed stream: R, SW, ADDI, J -> 4, 4, 4, 3 cycles; memwrite exactly once; retired=4.
- Illegal: op=111111 -> illegal_op pulses 1 cycle in DECODE; FETCH follows; retired unchanged; no regwrite or memwrite.
- MEM_WAIT_EN: hold mem_ready=0 for 3 cycles in FETCH -> irwrite and pcen stay 0; both fire once, in the cycle mem_ready=1.
